// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: launch/control inputs, instruction-memory port and decode-side outputs.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [1:0]        prog_sel;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] address;
  logic [31:0]       instrucao;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              running;
  logic              halted;
  logic              fault;

  modport master (
    input  start, prog_sel, stall, branch_taken, branch_target, instrucao,
    output address, instr_out, instr_pc, instr_valid, running, halted, fault
  );

  modport slave (
    output start, prog_sel, stall, branch_taken, branch_target, instrucao,
    input  address, instr_out, instr_pc, instr_valid, running, halted, fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: launches resident programs, fetches sequentially, resolves
// jumps locally, accepts branch redirects and halts on halt words or out-of-range addresses.
module instruction_fetch #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_LAST   = 80,
  parameter int unsigned PROG0_BASE = 1,
  parameter int unsigned PROG1_BASE = 15,
  parameter int unsigned PROG2_BASE = 30
) (
  input logic                clock,
  input logic                reset,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W:0] LAST_EXT = (ADDR_W+1)'(MEM_LAST);
  localparam logic [5:0]      JUMP_OP  = 6'b010000;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] ipc, ipc_nx;
  logic [31:0]       iout, iout_nx;
  logic              valid, valid_nx;
  logic              fault, fault_nx;
  logic              running, halted;

  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] jump_tgt_c;
  logic [ADDR_W:0]   pc_inc_c;
  logic              is_jump_c;

  // Program base selection; code 3 aliases program 0.
  always_comb begin
    base_c = ADDR_W'(PROG0_BASE);
    case (bus.prog_sel)
      2'd1:    base_c = ADDR_W'(PROG1_BASE);
      2'd2:    base_c = ADDR_W'(PROG2_BASE);
      default: base_c = ADDR_W'(PROG0_BASE);
    endcase
  end

  assign pc_inc_c   = {1'b0, pc} + (ADDR_W+1)'(1);
  assign jump_tgt_c = bus.instrucao[ADDR_W-1:0];
  assign is_jump_c  = (bus.instrucao[31:26] == JUMP_OP);

  // Next-state and datapath; branch beats stall beats halt/range beats jump beats sequential.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ipc_nx   = ipc;
    iout_nx  = iout;
    valid_nx = valid;
    fault_nx = fault;
    case (state)
      IDLE, HALT: begin
        valid_nx = 1'b0;
        if (bus.start) begin
          state_nx = FETCH;
          pc_nx    = base_c;
          fault_nx = 1'b0;
        end
      end
      FETCH: begin
        if (bus.branch_taken) begin
          valid_nx = 1'b0;
          if ({1'b0, bus.branch_target} > LAST_EXT) begin
            state_nx = HALT;
            fault_nx = 1'b1;
          end else begin
            pc_nx = bus.branch_target;
          end
        end else if (!bus.stall) begin
          iout_nx  = bus.instrucao;
          ipc_nx   = pc;
          valid_nx = 1'b0;
          if (bus.instrucao == 32'h0000_0000) begin
            state_nx = HALT;
          end else if (is_jump_c) begin
            if ({1'b0, jump_tgt_c} > LAST_EXT) begin
              state_nx = HALT;
              fault_nx = 1'b1;
            end else begin
              pc_nx = jump_tgt_c;
            end
          end else if (pc_inc_c > LAST_EXT) begin
            state_nx = HALT;
            fault_nx = 1'b1;
          end else begin
            pc_nx    = pc_inc_c[ADDR_W-1:0];
            valid_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      ipc     <= '0;
      iout    <= '0;
      valid   <= 1'b0;
      fault   <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      ipc     <= ipc_nx;
      iout    <= iout_nx;
      valid   <= valid_nx;
      fault   <= fault_nx;
      running <= (state_nx == FETCH);
      halted  <= (state_nx == HALT);
    end
  end

  assign bus.address     = pc;
  assign bus.instr_out   = iout;
  assign bus.instr_pc    = ipc;
  assign bus.instr_valid = valid;
  assign bus.running     = running;
  assign bus.halted      = halted;
  assign bus.fault       = fault;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: ADDR_W, 10, width of the instruction-memory address.
REQ-002 Parameter: MEM_LAST, 80, highest valid instruction-memory address.
REQ-003 Parameters: PROG0_BASE 1, PROG1_BASE 15, PROG2_BASE 30; start addresses of the resident programs.
REQ-004 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle pulse that launches the program selected by prog_sel.
REQ-007 Port: prog_sel  input  2  program select: 0, 1, 2 select PROG0/1/2_BASE; 3 selects PROG0_BASE.
REQ-008 Port: stall  input  1  downstream not ready; hold all fetch state.
REQ-009 Port: branch_taken  input  1  downstream resolved a taken branch this cycle.
REQ-010 Port: branch_target  input  ADDR_W  redirect address accompanying branch_taken.
REQ-011 Port: address  output  ADDR_W  instruction-memory read address, equal to the pc register.
REQ-012 Port: instrucao  input  32  combinational read data from instruction memory at address.
REQ-013 Port: instr_out  output  32  registered instruction for decode.
REQ-014 Port: instr_pc  output  ADDR_W  address from which instr_out was fetched.
REQ-015 Port: instr_valid  output  1  instr_out holds an instruction to execute.
REQ-016 Port: running  output  1  high in state FETCH.
REQ-017 Port: halted  output  1  high in state HALT.
REQ-018 Port: fault  output  1  sticky; set when HALT is entered through an address-range violation.

Function
REQ-019 The block shall implement three states: IDLE, FETCH and HALT.
REQ-020 In IDLE, start shall load pc with the selected base address and move to FETCH at the next edge; all other inputs are ignored.
REQ-021 In FETCH with no stall and no branch_taken, each edge shall load instr_out <= instrucao and instr_pc <= pc.
REQ-022 Fetch latency shall be one cycle: the word at address A appears on instr_out at the edge after address = A.
REQ-023 Sequential fetch shall advance pc <= pc + 1 and set instr_valid <= 1.
REQ-024 Jump is resolved in fetch: when instrucao[31:26] = 6'b010000, pc <= instrucao[ADDR_W-1:0] and instr_valid <= 0, so the jump is not forwarded.
REQ-025 A halt word (instrucao = 32'h0000_0000) shall cause a move to HALT with instr_valid <= 0 and fault unchanged.
REQ-026 pc + 1 > MEM_LAST, or a jump or branch target > MEM_LAST, shall cause a move to HALT with fault <= 1 and instr_valid <= 0.
REQ-027 branch_taken in FETCH shall set pc <= branch_target and instr_valid <= 0, flushing the word fetched that cycle.
REQ-028 Priority in FETCH shall be: branch_taken > stall > halt/range check > jump > sequential.
REQ-029 While stall is high and branch_taken is low, pc, instr_out, instr_pc and instr_valid shall hold their values.
REQ-030 start in FETCH shall be ignored; start in HALT shall relaunch as from IDLE and clear fault.
REQ-031 branch_taken and stall in IDLE or HALT shall be ignored.
REQ-032 In HALT, instr_valid shall be 0 and pc shall hold its last value.

Reset
REQ-033 While reset is high: state = IDLE, pc = 0, instr_out = 0, instr_pc = 0, instr_valid = 0, running = 0, halted = 0, fault = 0, independent of clock.
REQ-034 Reset asserted mid-program shall abort immediately; the next start shall fetch from the selected base address.

Verification
REQ-035 Sequential fetch: start with prog_sel = 0 -> address 1, 2, 3 on consecutive cycles; instr_pc lags address by one cycle; instr_valid = 1 from the second FETCH cycle.
REQ-036 Jump: word at address 11 = jump to 7 -> address goes 11 then 7; instr_valid = 0 for the cycle carrying the jump; no instr_pc = 12 is ever valid.
REQ-037 Branch flush: branch_taken with target 61 while address = 9 -> next address 61, instr_valid = 0 for one cycle; same result with stall = 1 applied simultaneously.
REQ-038 Stall: stall high 3 cycles at address 20 -> address, instr_out and instr_pc are frozen; fetch resumes at 20 with no word lost or duplicated.
REQ-039 Bounds: jump target 90 -> halted = 1, fault = 1, instr_valid = 0; a later start with prog_sel = 2 -> fault = 0, address = 30.
REQ-040 Async reset: assert reset between clock edges during FETCH -> all outputs reach reset values before the next edge.
